alu_control: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 53 +++++
 rtl/alu_control_decode.sv | 49 ++++
 rtl/alu_control.sv | 49 ++++
 tb/tb_alu_control.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the RV32I ALU control decoder: ALUOp classes,
// ALU operation codes and the funct7/funct3 values the decoder looks at.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Operation selected by funct3 alone when funct7 carries no alternate meaning.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALUOp/funct7/funct3 decode to an ALU operation code.
// Unsupported encodings report illegal and fall back to ADD.
module alu_control_decode
  import alu_ctrl_pkg::*;
(
  input  aluop_e      aluop,
  input  logic [6:0]  func7,
  input  logic [2:0]  func3,
  output alu_op_e     alu_op,
  output logic        illegal
);

  // MEM/BRANCH branches never read func7/func3, so X there cannot leak through.
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM:    alu_op = ALU_ADD;
      ALUOP_BRANCH: alu_op = ALU_SUB;
      ALUOP_RTYPE: begin
        if (func7 == F7_BASE) begin
          alu_op = base_op(func3);
        end else if ((func7 == F7_ALT) && (func3 == F3_ADD_SUB)) begin
          alu_op = ALU_SUB;
        end else if ((func7 == F7_ALT) && (func3 == F3_SRL_SRA)) begin
          alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      ALUOP_ITYPE: begin
        case (func3)
          F3_SLL: begin
            if (func7 == F7_BASE) alu_op = ALU_SLL;
            else                  illegal = 1'b1;
          end
          F3_SRL_SRA: begin
            if (func7 == F7_BASE)     alu_op = ALU_SRL;
            else if (func7 == F7_ALT) alu_op = ALU_SRA;
            else                      illegal = 1'b1;
          end
          default: alu_op = base_op(func3);
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control decoder with a registered output stage: one cycle latency,
// one decode per cycle, outputs hold when no valid input is presented.
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] ALUOp_in,
  input  logic [6:0] func7,
  input  logic [2:0] func3,
  output logic [3:0] AluControl_out,
  output logic       out_valid,
  output logic       illegal_op
);

  alu_op_e dec_op;
  logic    dec_illegal;
  alu_op_e op_q;
  logic    valid_q;
  logic    illegal_q;

  alu_control_decode u_decode (
    .aluop   (aluop_e'(ALUOp_in)),
    .func7   (func7),
    .func3   (func3),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= ALU_ADD;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (in_valid) begin
      op_q      <= dec_op;
      valid_q   <= 1'b1;
      illegal_q <= dec_illegal;
    end else begin
      valid_q   <= 1'b0;
    end
  end

  assign AluControl_out = op_q;
  assign out_valid      = valid_q;
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed steps followed by random
// traffic, compared against a table-driven reference of the decode rules.
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] ALUOp_in;
  logic [6:0] func7;
  logic [2:0] func3;
  logic [3:0] AluControl_out;
  logic       out_valid;
  logic       illegal_op;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m_code;
  logic       m_valid;
  logic       m_ill;

  // ALU code per funct3 for the plain (funct7 = 0) encodings
  int r_tbl [8] = '{2, 4, 8, 9, 3, 5, 1, 0};

  alu_control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .ALUOp_in       (ALUOp_in),
    .func7          (func7),
    .func3          (func3),
    .AluControl_out (AluControl_out),
    .out_valid      (out_valid),
    .illegal_op     (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_dec(input int op, input int f7, input int f3,
                                  output int code, output bit ill);
    code = 2;
    ill  = 1'b0;
    if (op == 0) code = 2;
    else if (op == 1) code = 6;
    else if (op == 2) begin
      if (f7 == 0) code = r_tbl[f3];
      else if (f7 == 32 && f3 == 0) code = 6;
      else if (f7 == 32 && f3 == 5) code = 7;
      else ill = 1'b1;
    end else begin
      if (f3 == 1) begin
        if (f7 == 0) code = 4; else ill = 1'b1;
      end else if (f3 == 5) begin
        if (f7 == 0) code = 5;
        else if (f7 == 32) code = 7;
        else ill = 1'b1;
      end else code = r_tbl[f3];
    end
    if (ill) code = 2;
  endfunction

  task automatic check(input string tag);
    n_assert++;
    assert (AluControl_out === m_code) else begin
      n_fail++;
      $error("FAIL %s code: got %b expected %b", tag, AluControl_out, m_code);
    end
    n_assert++;
    assert (out_valid === m_valid) else begin
      n_fail++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, m_valid);
    end
    n_assert++;
    assert (illegal_op === m_ill) else begin
      n_fail++;
      $error("FAIL %s illegal_op: got %b expected %b", tag, illegal_op, m_ill);
    end
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [6:0] f7,
                      input logic [2:0] f3, input string tag);
    int c;
    bit i;
    in_valid = v;
    ALUOp_in = op;
    func7    = f7;
    func3    = f3;
    @(posedge clk);
    #1;
    if (v) begin
      ref_dec(int'(op), int'(f7), int'(f3), c, i);
      m_code  = 4'(c);
      m_ill   = i;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    check(tag);
  endtask

  task automatic model_reset();
    m_code  = 4'b0010;
    m_valid = 1'b0;
    m_ill   = 1'b0;
  endtask

  initial begin
    logic [6:0] rf7;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ALUOp_in = 2'b00;
    func7    = 7'd0;
    func3    = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("in_reset");
    rst_n = 1'b1;
    step(1'b0, 2'b00, 7'd0, 3'd0, "after_release");

    step(1'b1, 2'b00, 7'bx, 3'bx, "mem_x");
    step(1'b1, 2'b01, 7'bx, 3'bx, "branch_x");

    step(1'b1, 2'b10, 7'b0000000, 3'b000, "r_add");
    step(1'b1, 2'b10, 7'b0000000, 3'b111, "r_and");
    step(1'b1, 2'b10, 7'b0000000, 3'b110, "r_or");
    step(1'b1, 2'b10, 7'b0000000, 3'b100, "r_xor");

    step(1'b1, 2'b10, 7'b0100000, 3'b000, "r_sub");
    step(1'b1, 2'b10, 7'b0100000, 3'b101, "r_sra");
    step(1'b1, 2'b10, 7'b0100000, 3'b111, "r_alt_illegal");
    step(1'b1, 2'b10, 7'b0000001, 3'b000, "r_mext_illegal");
    step(1'b1, 2'b10, 7'b0000000, 3'b001, "r_sll_clears_ill");

    step(1'b1, 2'b11, 7'b1111111, 3'b000, "i_add_f7_ignored");
    step(1'b1, 2'b11, 7'b0100000, 3'b101, "i_sra");
    step(1'b1, 2'b11, 7'b0100000, 3'b001, "i_sll_illegal");
    step(1'b1, 2'b11, 7'b0000000, 3'b011, "i_sltu");
    step(1'b1, 2'b11, 7'b0000000, 3'b101, "i_srl");

    step(1'b1, 2'b10, 7'b0000000, 3'b010, "r_slt");
    step(1'b0, 2'b11, 7'b0100000, 3'b001, "gate_hold");
    step(1'b0, 2'b01, 7'b0000000, 3'b000, "gate_hold2");

    step(1'b1, 2'b10, 7'b0100000, 3'b011, "pre_reset_illegal");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(posedge clk);
    #1;
    check("reset_held");
    rst_n = 1'b1;
    step(1'b1, 2'b10, 7'b0100000, 3'b000, "post_reset_sub");

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(3, 0))
        0: rf7 = 7'b0000000;
        1: rf7 = 7'b0100000;
        2: rf7 = 7'b0000001;
        default: rf7 = 7'($urandom);
      endcase
      step(($urandom_range(9, 0) < 8), 2'($urandom), rf7, 3'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
